pll_reconfig_seq: RTL and testbench

//  Sequences run-time retuning of one output counter (C0..C17) of the fabric PLL through the PLL reconfiguration
//  IP's Avalon-MM management port. Accepts one counter-update request per handshake, performs the write sequence,

---
 rtl/pll_reconfig_pkg.sv | 48 ++++
 rtl/pll_lock_filter.sv | 43 ++++
 rtl/pll_reconfig_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_pll_reconfig_seq.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_reconfig_pkg.sv
// Shared definitions for the PLL counter-retuning sequencer: reconfig register map,
// sequencer states and the C-counter write word layout.
package pll_reconfig_pkg;

    localparam logic [5:0] REG_MODE   = 6'h00;
    localparam logic [5:0] REG_STATUS = 6'h01;
    localparam logic [5:0] REG_START  = 6'h02;
    localparam logic [5:0] REG_C_CNT  = 6'h05;

    localparam int CC_LO_OFS  = 0;
    localparam int CC_HI_OFS  = 8;
    localparam int CC_BYP_BIT = 16;
    localparam int CC_ODD_BIT = 17;
    localparam int CC_SEL_OFS = 18;

    localparam logic [4:0] MAX_CNT_SEL = 5'd17;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_MODE,
        ST_WR_CCNT,
        ST_WR_START,
        ST_RD_STAT,
        ST_WAIT_LOCK,
        ST_DONE,
        ST_ERR
    } state_t;

    typedef struct packed {
        logic [4:0] sel;
        logic       odd;
        logic       bypass;
        logic [7:0] hi;
        logic [7:0] lo;
    } cnt_req_t;

    function automatic logic [31:0] ccnt_word(input cnt_req_t r);
        logic [31:0] w;
        w = '0;
        w[CC_LO_OFS +: 8]  = r.lo;
        w[CC_HI_OFS +: 8]  = r.hi;
        w[CC_BYP_BIT]      = r.bypass;
        w[CC_ODD_BIT]      = r.odd;
        w[CC_SEL_OFS +: 5] = r.sel;
        return w;
    endfunction

endpackage

// File: rtl/pll_lock_filter.sv
// Synchronises the asynchronous PLL lock and reports lock_stable once it has been
// high for LOCK_STABLE consecutive cycles; clr restarts the qualification window.
module pll_lock_filter
    import pll_reconfig_pkg::*;
#(
    parameter int LOCK_STABLE = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic pll_locked,
    output logic lock_stable
);

    localparam int CNT_W = $clog2(LOCK_STABLE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_STABLE);

    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync_d = {sync_q[0], pll_locked};
        cnt_d  = cnt_q;
        if (clr || !sync_q[1]) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
        end
    end

    assign lock_stable = sync_q[1] && (cnt_q == CNT_MAX);

endmodule

// File: rtl/pll_reconfig_seq.sv
// Retunes one PLL output counter through the reconfig core's Avalon-MM port, then holds
// user_rst until the PLL has relocked stably. All outputs are registered.
module pll_reconfig_seq
    import pll_reconfig_pkg::*;
#(
    parameter int LOCK_STABLE  = 256,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int POLL_LIMIT   = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [4:0]  cfg_cnt_sel,
    input  logic [7:0]  cfg_hi,
    input  logic [7:0]  cfg_lo,
    input  logic        cfg_bypass,
    input  logic        cfg_odd,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic        mgmt_read,
    output logic [31:0] mgmt_writedata,
    input  logic [31:0] mgmt_readdata,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked,
    output logic        user_rst,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int TMO_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam int POLL_W = $clog2(POLL_LIMIT + 2);
    localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(LOCK_TIMEOUT);
    localparam logic [POLL_W-1:0] POLL_MAX = POLL_W'(POLL_LIMIT);

    state_t             state_q, state_d;
    cnt_req_t           req_q, req_d;
    logic [POLL_W-1:0]  poll_cnt_q, poll_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [5:0]         mgmt_address_q, mgmt_address_d;
    logic               mgmt_write_q, mgmt_write_d;
    logic               mgmt_read_q, mgmt_read_d;
    logic [31:0]        mgmt_writedata_q, mgmt_writedata_d;
    logic               cfg_ready_q, cfg_ready_d;
    logic               user_rst_q, user_rst_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               lock_clr;
    logic               lock_stable;
    logic               unused_rd;

    assign unused_rd = ^mgmt_readdata[31:1];

    pll_lock_filter #(
        .LOCK_STABLE (LOCK_STABLE)
    ) u_lock_filter (
        .clk         (clk),
        .rst         (rst),
        .clr         (lock_clr),
        .pll_locked  (pll_locked),
        .lock_stable (lock_stable)
    );

    always_comb begin
        state_d          = state_q;
        req_d            = req_q;
        poll_cnt_d       = poll_cnt_q;
        tmo_cnt_d        = tmo_cnt_q;
        mgmt_address_d   = mgmt_address_q;
        mgmt_write_d     = mgmt_write_q;
        mgmt_read_d      = mgmt_read_q;
        mgmt_writedata_d = mgmt_writedata_q;
        cfg_ready_d      = cfg_ready_q;
        user_rst_d       = user_rst_q;
        busy_d           = busy_q;
        done_d           = 1'b0;
        error_d          = error_q;
        lock_clr         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // After a failed update the clock is untrusted: keep user_rst until a new request.
                user_rst_d = !lock_stable || (error_q && user_rst_q);
                if (cfg_valid && cfg_ready_q) begin
                    req_d.sel    = cfg_cnt_sel;
                    req_d.odd    = cfg_odd;
                    req_d.bypass = cfg_bypass;
                    req_d.hi     = cfg_hi;
                    req_d.lo     = cfg_lo;
                    error_d      = 1'b0;
                    if (cfg_cnt_sel > MAX_CNT_SEL) begin
                        error_d = 1'b1;
                    end else begin
                        state_d          = ST_WR_MODE;
                        cfg_ready_d      = 1'b0;
                        busy_d           = 1'b1;
                        user_rst_d       = 1'b1;
                        mgmt_write_d     = 1'b1;
                        mgmt_address_d   = REG_MODE;
                        mgmt_writedata_d = 32'h1;
                    end
                end
            end
            ST_WR_MODE: begin
                if (!mgmt_waitrequest) begin
                    state_d          = ST_WR_CCNT;
                    mgmt_address_d   = REG_C_CNT;
                    mgmt_writedata_d = ccnt_word(req_q);
                end
            end
            ST_WR_CCNT: begin
                if (!mgmt_waitrequest) begin
                    state_d          = ST_WR_START;
                    mgmt_address_d   = REG_START;
                    mgmt_writedata_d = 32'h1;
                end
            end
            ST_WR_START: begin
                if (!mgmt_waitrequest) begin
                    state_d          = ST_RD_STAT;
                    mgmt_write_d     = 1'b0;
                    mgmt_read_d      = 1'b1;
                    mgmt_address_d   = REG_STATUS;
                    mgmt_writedata_d = '0;
                    lock_clr         = 1'b1;
                    tmo_cnt_d        = '0;
                    poll_cnt_d       = '0;
                end
            end
            ST_RD_STAT: begin
                if (tmo_cnt_q != TMO_MAX) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                // The read stays asserted, so each un-stalled cycle is a fresh status poll.
                if (!mgmt_waitrequest) begin
                    if (mgmt_readdata[0]) begin
                        state_d        = ST_WAIT_LOCK;
                        mgmt_read_d    = 1'b0;
                        mgmt_address_d = '0;
                    end else if (poll_cnt_q >= POLL_MAX || tmo_cnt_q == TMO_MAX) begin
                        state_d        = ST_ERR;
                        mgmt_read_d    = 1'b0;
                        mgmt_address_d = '0;
                        error_d        = 1'b1;
                    end else begin
                        poll_cnt_d = poll_cnt_q + POLL_W'(1);
                    end
                end
            end
            ST_WAIT_LOCK: begin
                if (tmo_cnt_q != TMO_MAX) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                if (lock_stable) begin
                    state_d    = ST_DONE;
                    done_d     = 1'b1;
                    user_rst_d = 1'b0;
                end else if (tmo_cnt_q == TMO_MAX) begin
                    state_d = ST_ERR;
                    error_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                busy_d      = 1'b0;
                cfg_ready_d = 1'b1;
            end
            ST_ERR: begin
                state_d     = ST_IDLE;
                busy_d      = 1'b0;
                cfg_ready_d = 1'b1;
                user_rst_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            req_q            <= '0;
            poll_cnt_q       <= '0;
            tmo_cnt_q        <= '0;
            mgmt_address_q   <= '0;
            mgmt_write_q     <= 1'b0;
            mgmt_read_q      <= 1'b0;
            mgmt_writedata_q <= '0;
            cfg_ready_q      <= 1'b1;
            user_rst_q       <= 1'b1;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            error_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            req_q            <= req_d;
            poll_cnt_q       <= poll_cnt_d;
            tmo_cnt_q        <= tmo_cnt_d;
            mgmt_address_q   <= mgmt_address_d;
            mgmt_write_q     <= mgmt_write_d;
            mgmt_read_q      <= mgmt_read_d;
            mgmt_writedata_q <= mgmt_writedata_d;
            cfg_ready_q      <= cfg_ready_d;
            user_rst_q       <= user_rst_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            error_q          <= error_d;
        end
    end

    assign cfg_ready      = cfg_ready_q;
    assign mgmt_address   = mgmt_address_q;
    assign mgmt_write     = mgmt_write_q;
    assign mgmt_read      = mgmt_read_q;
    assign mgmt_writedata = mgmt_writedata_q;
    assign user_rst       = user_rst_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed bench for pll_reconfig_seq with a small Avalon responder and scaled-down
// lock/poll/timeout parameters so every sequence finishes in a few hundred cycles.
module tb_pll_reconfig_seq;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [4:0]  cfg_cnt_sel;
    logic [7:0]  cfg_hi;
    logic [7:0]  cfg_lo;
    logic        cfg_bypass;
    logic        cfg_odd;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic        mgmt_read;
    logic [31:0] mgmt_writedata;
    logic [31:0] mgmt_readdata;
    logic        mgmt_waitrequest;
    logic        pll_locked;
    logic        user_rst;
    logic        busy;
    logic        done;
    logic        error;

    int n_chk = 0;
    int n_err = 0;

    int wait_cfg;
    int status_at;
    int wait_left;
    int held;
    logic [5:0]  h_addr;
    logic [31:0] h_data;
    logic        h_wr;
    int wr_cnt;
    int rd_cnt;
    logic [5:0]  wr_addr [8];
    logic [31:0] wr_data [8];

    int done_cyc, err_cyc, end_cyc;
    logic c0_rst, c0_busy, c0_ready, c0_err;

    pll_reconfig_seq #(
        .LOCK_STABLE  (8),
        .LOCK_TIMEOUT (60),
        .POLL_LIMIT   (5)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_valid        (cfg_valid),
        .cfg_ready        (cfg_ready),
        .cfg_cnt_sel      (cfg_cnt_sel),
        .cfg_hi           (cfg_hi),
        .cfg_lo           (cfg_lo),
        .cfg_bypass       (cfg_bypass),
        .cfg_odd          (cfg_odd),
        .mgmt_address     (mgmt_address),
        .mgmt_write       (mgmt_write),
        .mgmt_read        (mgmt_read),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_readdata    (mgmt_readdata),
        .mgmt_waitrequest (mgmt_waitrequest),
        .pll_locked       (pll_locked),
        .user_rst         (user_rst),
        .busy             (busy),
        .done             (done),
        .error            (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Avalon responder: stalls each command wait_cfg cycles, logs writes, answers status reads.
    initial begin
        mgmt_waitrequest = 1'b0;
        mgmt_readdata    = '0;
        wait_left        = 0;
        held             = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mgmt_waitrequest = 1'b0;
                held             = 0;
                wait_left        = wait_cfg;
            end else if (mgmt_write || mgmt_read) begin
                chk("rw_excl", 32'(mgmt_write & mgmt_read), 32'd0);
                if (held != 0) begin
                    chk("hold_addr", 32'(mgmt_address), 32'(h_addr));
                    chk("hold_data", mgmt_writedata, h_data);
                    chk("hold_wr", 32'(mgmt_write), 32'(h_wr));
                end
                if (wait_left > 0) begin
                    mgmt_waitrequest = 1'b1;
                    wait_left--;
                    held   = 1;
                    h_addr = mgmt_address;
                    h_data = mgmt_writedata;
                    h_wr   = mgmt_write;
                end else begin
                    mgmt_waitrequest = 1'b0;
                    held             = 0;
                    wait_left        = wait_cfg;
                    if (mgmt_write) begin
                        if (wr_cnt < 8) begin
                            wr_addr[wr_cnt] = mgmt_address;
                            wr_data[wr_cnt] = mgmt_writedata;
                        end
                        wr_cnt++;
                    end else begin
                        rd_cnt++;
                        mgmt_readdata = {31'h2AAA_AAAA,
                                         (status_at != 0 && rd_cnt >= status_at)};
                    end
                end
            end else begin
                mgmt_waitrequest = 1'b0;
                held             = 0;
                wait_left        = wait_cfg;
            end
        end
    end

    task automatic send(input logic [4:0] sel, input logic [7:0] hi, input logic [7:0] lo,
                        input logic byp, input logic odd);
        wr_cnt = 0;
        rd_cnt = 0;
        @(negedge clk);
        chk("cfg_ready_pre", 32'(cfg_ready), 32'd1);
        cfg_valid   = 1'b1;
        cfg_cnt_sel = sel;
        cfg_hi      = hi;
        cfg_lo      = lo;
        cfg_bypass  = byp;
        cfg_odd     = odd;
        @(posedge clk);
        #1 cfg_valid = 1'b0;
    endtask

    // Cycle c is sampled after the c-th edge following the accepting edge.
    task automatic run_seq(input int max_cyc, input int tog);
        bit fin;
        fin      = 0;
        done_cyc = -1;
        err_cyc  = -1;
        end_cyc  = -1;
        for (int c = 0; c < max_cyc && !fin; c++) begin
            @(negedge clk);
            if (done && done_cyc < 0) done_cyc = c;
            if (error && err_cyc < 0) err_cyc = c;
            if (c == 0) begin
                c0_rst   = user_rst;
                c0_busy  = busy;
                c0_ready = cfg_ready;
                c0_err   = error;
            end
            if (tog > 0 && (c % tog) == tog - 1) pll_locked = !pll_locked;
            if (cfg_ready) begin
                fin     = 1;
                end_cyc = c;
            end
        end
        if (!fin) chk("seq_timeout", 32'(fin), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        cfg_valid   = 1'b0;
        cfg_cnt_sel = '0;
        cfg_hi      = '0;
        cfg_lo      = '0;
        cfg_bypass  = 1'b0;
        cfg_odd     = 1'b0;
        pll_locked  = 1'b0;
        wait_cfg    = 0;
        status_at   = 0;
        wr_cnt      = 0;
        rd_cnt      = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("rst_write", 32'(mgmt_write), 32'd0);
        chk("rst_read", 32'(mgmt_read), 32'd0);
        chk("rst_addr", 32'(mgmt_address), 32'd0);
        chk("rst_wdata", mgmt_writedata, 32'd0);
        chk("rst_user_rst", 32'(user_rst), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);

        // Lock qualification after reset: release needs sync(2) + 8 stable + 1 register
        pll_locked = 1'b1;
        rst        = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_rst_hold", 32'(user_rst), 32'd1);
        repeat (15) @(negedge clk);
        chk("idle_rst_release", 32'(user_rst), 32'd0);

        // Lock drop while idle
        pll_locked = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_drop_rst", 32'(user_rst), 32'd1);
        pll_locked = 1'b1;
        repeat (15) @(negedge clk);
        chk("idle_relock", 32'(user_rst), 32'd0);

        // Test 1: nominal update, status on 4th read
        wait_cfg  = 0;
        status_at = 4;
        send(5'd2, 8'd4, 8'd4, 1'b0, 1'b0);
        run_seq(100, 0);
        chk("t1_user_rst_c0", 32'(c0_rst), 32'd1);
        chk("t1_busy_c0", 32'(c0_busy), 32'd1);
        chk("t1_ready_c0", 32'(c0_ready), 32'd0);
        chk("t1_wr_cnt", 32'(wr_cnt), 32'd3);
        chk("t1_wr0_addr", 32'(wr_addr[0]), 32'h00);
        chk("t1_wr0_data", wr_data[0], 32'h1);
        chk("t1_wr1_addr", 32'(wr_addr[1]), 32'h05);
        chk("t1_wr1_data", wr_data[1], 32'h0008_0404);
        chk("t1_wr2_addr", 32'(wr_addr[2]), 32'h02);
        chk("t1_wr2_data", wr_data[2], 32'h1);
        chk("t1_rd_cnt", 32'(rd_cnt), 32'd4);
        chk("t1_done_cyc", 32'(done_cyc), 32'd12);
        chk("t1_end_cyc", 32'(end_cyc), 32'd13);
        chk("t1_done_pulse", 32'(done), 32'd0);
        chk("t1_user_rst_end", 32'(user_rst), 32'd0);
        chk("t1_busy_end", 32'(busy), 32'd0);

        // Test 2: five wait states on every command
        wait_cfg  = 5;
        status_at = 1;
        send(5'd17, 8'h12, 8'h34, 1'b1, 1'b1);
        run_seq(300, 0);
        chk("t2_wr_cnt", 32'(wr_cnt), 32'd3);
        chk("t2_wr0_addr", 32'(wr_addr[0]), 32'h00);
        chk("t2_wr1_addr", 32'(wr_addr[1]), 32'h05);
        chk("t2_wr1_data", wr_data[1], 32'h0047_1234);
        chk("t2_wr2_addr", 32'(wr_addr[2]), 32'h02);
        chk("t2_rd_cnt", 32'(rd_cnt), 32'd1);
        chk("t2_done_seen", 32'(done_cyc >= 0), 32'd1);
        chk("t2_user_rst_end", 32'(user_rst), 32'd0);

        // Test 3: invalid counter select
        wait_cfg  = 0;
        send(5'd18, 8'd1, 8'd1, 1'b0, 1'b0);
        run_seq(10, 0);
        repeat (3) @(negedge clk);
        chk("t3_error_c0", 32'(c0_err), 32'd1);
        chk("t3_ready_c0", 32'(c0_ready), 32'd1);
        chk("t3_busy_c0", 32'(c0_busy), 32'd0);
        chk("t3_no_wr", 32'(wr_cnt), 32'd0);
        chk("t3_no_rd", 32'(rd_cnt), 32'd0);
        chk("t3_error_sticky", 32'(error), 32'd1);

        // Test 4: lock toggling every 5 cycles never qualifies; timeout after 60
        status_at = 1;
        send(5'd3, 8'd2, 8'd3, 1'b0, 1'b1);
        run_seq(200, 5);
        chk("t4_error_cleared", 32'(c0_err), 32'd0);
        chk("t4_err_cyc", 32'(err_cyc), 32'd64);
        chk("t4_no_done", 32'(done_cyc < 0), 32'd1);
        pll_locked = 1'b1;
        repeat (20) @(negedge clk);
        chk("t4_user_rst_held", 32'(user_rst), 32'd1);

        // Test 5: status never completes
        status_at = 0;
        send(5'd0, 8'd8, 8'd8, 1'b0, 1'b0);
        run_seq(100, 0);
        chk("t5_err_cyc", 32'(err_cyc), 32'd9);
        chk("t5_rd_cnt", 32'(rd_cnt), 32'd6);
        chk("t5_no_done", 32'(done_cyc < 0), 32'd1);
        repeat (20) @(negedge clk);
        chk("t5_user_rst_held", 32'(user_rst), 32'd1);

        // Test 6: reset while polling status
        send(5'd1, 8'd5, 8'd5, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        chk("t6_in_rd_stat", 32'(mgmt_read), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_write", 32'(mgmt_write), 32'd0);
        chk("t6_read", 32'(mgmt_read), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_user_rst", 32'(user_rst), 32'd1);
        chk("t6_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("t6_error", 32'(error), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
